// File: rtl/alu_sequencer.sv
// Round-robin scheduler for two requesters sharing one edge-triggered ALU.
// Owns the accumulator and sequences each operation so the ALU sees a fresh A-side edge.
//
// state | meaning
// IDLE  | arbitrate; accept a request, LOAD writes acc directly
// SETUP | apply opcode/operand, drive A-side with ~acc
// KICK  | return A-side to acc so the ALU re-evaluates with the new opcode
// CAPT  | hold ALU ports, capture alu_result into acc
// RESP  | return acc to the served requester
module alu_sequencer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    input  logic [1:0]       req_op0,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [1:0]       req_op1,
    input  logic [WIDTH-1:0] req_data1,
    output logic [1:0]       req_ready,
    output logic [1:0]       resp_valid,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy,
    output logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [1:0]       alu_en,
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        KICK  = 3'd2,
        CAPT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] resp_hold;
    logic [1:0]       op;
    logic             last_grant;
    logic             grant;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_data;

    // Contention goes to whoever was not served last; otherwise the sole requester wins.
    assign grant    = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    assign sel_op   = grant ? req_op1 : req_op0;
    assign sel_data = grant ? req_data1 : req_data0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            operand    <= '0;
            op         <= OP_LOAD;
            last_grant <= 1'b1;
            resp_hold  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        last_grant <= grant;
                        op         <= sel_op;
                        operand    <= sel_data;
                        if (sel_op == OP_LOAD) begin
                            acc <= sel_data;
                        end
                    end
                end
                CAPT:    acc <= alu_result;
                RESP:    resp_hold <= acc;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        resp_data  = resp_hold;
        busy       = (state != IDLE);
        alu_en     = 2'b00;
        alu_b      = '0;
        alu_a      = acc;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = grant ? 2'b10 : 2'b01;
                    state_nx  = (sel_op == OP_LOAD) ? RESP : SETUP;
                end
            end
            SETUP: begin
                alu_en   = op;
                alu_b    = operand;
                alu_a    = ~acc;
                state_nx = KICK;
            end
            KICK: begin
                alu_en   = op;
                alu_b    = operand;
                state_nx = CAPT;
            end
            CAPT: begin
                alu_en   = op;
                alu_b    = operand;
                state_nx = RESP;
            end
            RESP: begin
                resp_valid = last_grant ? 2'b10 : 2'b01;
                resp_data  = acc;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: an edge-triggered ALU model, a cycle-level
// reference of the sequencing rules, and a scoreboard monitor on the response port.
module tb_alu_sequencer;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_op0;
    logic [8:0] req_data0;
    logic [1:0] req_op1;
    logic [8:0] req_data1;
    logic [1:0] req_ready;
    logic [1:0] resp_valid;
    logic [8:0] resp_data;
    logic       busy;
    logic [8:0] alu_b;
    logic [8:0] alu_a;
    logic [1:0] alu_en;
    logic [8:0] alu_result = '0;

    alu_sequencer #(.WIDTH(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid),
        .req_op0(req_op0), .req_data0(req_data0),
        .req_op1(req_op1), .req_data1(req_data1),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .busy(busy), .alu_b(alu_b), .alu_a(alu_a), .alu_en(alu_en),
        .alu_result(alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] alu_f(input logic [1:0] en, input logic [8:0] b, input logic [8:0] a);
        case (en)
            2'b01:   return a + b;
            2'b10:   return a - b;
            2'b11:   return 9'($countones(b));
            default: return 9'd0;
        endcase
    endfunction

    // The ALU only re-evaluates when its A-side input moves.
    always @(alu_a) begin
        #1;
        alu_result = alu_f(alu_en, alu_b, alu_a);
    end

    typedef struct {
        logic [1:0] who;
        logic [8:0] data;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester-side intent and the reference model of the sequencer.
    logic [1:0] pend = 2'b00;
    logic [1:0] pop [2];
    logic [8:0] pdat[2];
    logic [8:0] m_acc  = '0;
    logic [8:0] m_prev = '0;
    logic [8:0] m_hold = '0;
    logic [8:0] m_opnd = '0;
    logic [1:0] m_op   = '0;
    logic [1:0] m_who  = '0;
    logic       m_last = 1'b1;
    logic       active = 1'b0;
    int         m_t    = 0;
    int         m_len  = 0;

    task automatic accept(input int w);
        m_prev = m_acc;
        m_op   = pop[w];
        m_opnd = pdat[w];
        case (m_op)
            2'b00: m_acc = m_opnd;
            2'b01: m_acc = m_acc + m_opnd;
            2'b10: m_acc = m_acc - m_opnd;
            default: m_acc = 9'($countones(m_opnd));
        endcase
        m_len  = (m_op == 2'b00) ? 1 : 4;
        m_who  = (w == 1) ? 2'b10 : 2'b01;
        exp_q.push_back('{who: m_who, data: m_acc});
        pend[w] = 1'b0;
        m_last  = (w == 1);
        active  = 1'b1;
        m_t     = 0;
    endtask

    task automatic step();
        int         w;
        logic [8:0] inv;
        @(negedge clk);
        req_valid = pend;
        req_op0   = pop[0];
        req_data0 = pdat[0];
        req_op1   = pop[1];
        req_data1 = pdat[1];
        #1;
        if (active) begin
            m_t++;
            if (m_t > m_len) active = 1'b0;
        end
        chk("busy", busy, active);
        if (active && m_len == 4 && m_t <= 3) begin
            inv = ~m_prev;
            chk("alu_en", alu_en, m_op);
            chk("alu_b", alu_b, m_opnd);
            chk("alu_a", alu_a, (m_t == 1) ? inv : m_prev);
        end else begin
            chk("alu_en_idle", alu_en, 2'b00);
            chk("alu_b_idle", alu_b, 9'd0);
            chk("alu_a_idle", alu_a, m_acc);
        end
        if (active && m_t == m_len) begin
            chk("resp_valid", resp_valid, m_who);
            m_hold = m_acc;
        end else begin
            chk("resp_valid_quiet", resp_valid, 2'b00);
            chk("resp_data_hold", resp_data, m_hold);
        end
        w = -1;
        if (!active) begin
            if (pend == 2'b11)  w = m_last ? 0 : 1;
            else if (pend[0])   w = 0;
            else if (pend[1])   w = 1;
        end
        chk("req_ready", req_ready, (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00);
        if (w >= 0) accept(w);
    endtask

    task automatic drain();
        int n = 0;
        while ((active || pend != 2'b00) && n < 60) begin
            step();
            n++;
        end
        chk("drain_timeout", (n < 60), 1);
    endtask

    task automatic issue(input int i, input logic [1:0] op, input logic [8:0] d);
        pend[i] = 1'b1;
        pop[i]  = op;
        pdat[i] = d;
        drain();
    endtask

    // Scoreboard monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst_n && resp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("spurious_resp", resp_valid, 2'b00);
            end else begin
                e = exp_q.pop_front();
                chk("resp_who", resp_valid, e.who);
                chk("resp_data", resp_data, e.data);
            end
        end
    end

    initial begin
        int rem0;
        int rem1;
        int n;
        pop[0] = '0; pop[1] = '0; pdat[0] = '0; pdat[1] = '0;
        rst_n = 1'b0;
        req_valid = '0; req_op0 = '0; req_data0 = '0; req_op1 = '0; req_data1 = '0;
        #12;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_resp_valid", resp_valid, 2'b00);
        chk("rst_resp_data", resp_data, 9'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_alu_en", alu_en, 2'b00);
        chk("rst_alu_b", alu_b, 9'd0);
        chk("rst_alu_a", alu_a, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(0, 2'b00, 9'h0A5);
        issue(1, 2'b01, 9'h15B);
        issue(0, 2'b00, 9'h003);
        issue(1, 2'b10, 9'h005);
        issue(0, 2'b11, 9'h1FF);
        issue(1, 2'b11, 9'h000);

        // Both requesters contend with ADD 1 from acc=0.
        issue(1, 2'b00, 9'h000);
        rem0 = 2; rem1 = 2; n = 0;
        while ((rem0 + rem1 > 0 || active || pend != 2'b00) && n < 80) begin
            if (!pend[0] && rem0 > 0) begin pend[0] = 1'b1; pop[0] = 2'b01; pdat[0] = 9'd1; rem0--; end
            if (!pend[1] && rem1 > 0) begin pend[1] = 1'b1; pop[1] = 2'b01; pdat[1] = 9'd1; rem1--; end
            step();
            n++;
        end
        chk("contend_timeout", (n < 80), 1);
        chk("contend_acc", m_acc, 9'd4);

        // Reset asserted during CAPT of an ADD aborts it.
        pend[0] = 1'b1; pop[0] = 2'b01; pdat[0] = 9'h011;
        step();
        step(); step(); step();
        chk("abort_in_capt", m_t, 3);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        m_acc = '0; m_hold = '0; m_last = 1'b1; active = 1'b0; pend = 2'b00;
        chk("abort_alu_en", alu_en, 2'b00);
        chk("abort_alu_b", alu_b, 9'd0);
        chk("abort_alu_a", alu_a, 9'd0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_resp_valid", resp_valid, 2'b00);
        chk("abort_resp_data", resp_data, 9'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 2'b00, 9'h1FF);

        // Requester 0 withdraws while requester 1 is being served.
        pend[1] = 1'b1; pop[1] = 2'b01; pdat[1] = 9'h022;
        step();
        pend[0] = 1'b1; pop[0] = 2'b10; pdat[0] = 9'h0F0;
        step(); step();
        pend[0] = 1'b0;
        drain();

        // Randomised traffic with occasional withdrawals.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    pop[i]  = 2'($urandom_range(0, 3));
                    pdat[i] = 9'($urandom_range(0, 511));
                end else if (pend[i] && $urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            step();
        end
        drain();
        step();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Two-requester scheduler and sequencer for the shared 9-bit ALU (opcodes 01 add, 10 sub, 11 popcount, 00 idle/zero).
- Owns the accumulator register that feeds the ALU A-side.
- Arbitrates round-robin between two requesters, drives the ALU ports in a fixed multi-cycle sequence, captures the result into the accumulator, and returns it to the winning requester.
- The ALU recomputes only on a change of its A-side input. The sequencer therefore forces an A-side transition on every operation.

Parameters:
WIDTH, 9, datapath width of accumulator, operands and ALU ports

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  2  per-requester request valid; bit i = requester i
req_op0  input  2  requester 0 opcode: 00 LOAD, 01 ADD, 10 SUB, 11 POP
req_data0  input  WIDTH  requester 0 operand
req_op1  input  2  requester 1 opcode
req_data1  input  WIDTH  requester 1 operand
req_ready  output  2  one-cycle accept pulse to the granted requester
resp_valid  output  2  one-cycle completion pulse to the requester that was served
resp_data  output  WIDTH  accumulator value; valid while resp_valid is nonzero
busy  output  1  high in every state except IDLE
alu_b  output  WIDTH  ALU B-side operand ("in")
alu_a  output  WIDTH  ALU A-side operand ("in_from_A")
alu_en  output  2  ALU opcode
alu_result  input  WIDTH  ALU output

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, acc=0, last_grant=1 (requester 0 wins first).
  - req_ready=0, resp_valid=0, resp_data=0, busy=0, alu_en=00, alu_b=0, alu_a=0.
  - Reset mid-operation aborts the operation: no response is issued and acc returns to 0.
- States: IDLE, SETUP, KICK, CAPT, RESP.
- IDLE:
  - If any req_valid bit is set, select winner w.
  - If only one bit is set, that requester wins.
  - If both are set, w = ~last_grant.
  - Assert req_ready[w] for this cycle. Latch op and operand of w. Set last_grant=w.
  - Latched op LOAD: acc<=operand at this edge; next state RESP.
  - Otherwise next state SETUP.
  - If no request, stay in IDLE.
- SETUP: alu_en=op, alu_b=operand, alu_a=~acc (bitwise inverse, always differs from acc). Next state KICK.
- KICK: alu_en and alu_b held, alu_a=acc. This guarantees an A-side transition, so the ALU evaluates with the correct opcode already applied. Next state CAPT.
- CAPT: ALU ports held. acc<=alu_result at the end of the cycle. Next state RESP.
- RESP: resp_valid[w]=1 and resp_data=acc for one cycle. Next state IDLE.
- req_valid sampled in RESP is ignored; it is arbitrated in the following IDLE cycle. Back-to-back throughput is therefore one op per 5 cycles (LOAD: one per 2).
- Outside SETUP/KICK/CAPT: alu_en=00, alu_b=0, alu_a=acc. The A-side stays stable, so there are no spurious ALU evaluations.
- resp_data holds the last response value between responses.
- Latency (accept edge at cycle T):
  - ADD/SUB/POP: acc updated at end of T+3; resp_valid in T+4.
  - LOAD: acc updated at end of T; resp_valid in T+1.
- Arithmetic (performed by the ALU, modulo 2^WIDTH):
  - ADD: acc+operand.
  - SUB: acc−operand; wraps on borrow.
  - POP: number of set bits in operand; acc ignored.
- Operands and op are latched at accept. Requesters may change or drop inputs after the req_ready pulse.
- A requester holds req_valid until it sees req_ready. Dropping req_valid before accept withdraws the request.
- At most one req_ready bit and at most one resp_valid bit are high in any cycle.

Test Plan:
- Reset then req_valid=01, op0=LOAD, data0=9'h0A5 -> req_ready=01 in the first IDLE cycle, resp_valid=01 next cycle, resp_data=0A5, alu_en stays 00.
- acc=0A5, requester 1 ADD 9'h15B -> alu_a sequence 15A (SETUP), 0A5 (KICK); alu_en=01 in SETUP/KICK/CAPT; resp_valid=10 four cycles after accept; resp_data=000 (wrap: 0A5+15B=200 mod 512).
- acc=003, SUB 9'h005 -> resp_data=1FE. Then POP 9'h1FF -> resp_data=009. Then POP 9'h000 -> 000.
- Both requesters hold req_valid with ADD 1 from acc=0 -> grants alternate 0,1,0,1; resp_data 1,2,3,4; never two ready bits at once; busy high from SETUP through RESP.
- Assert rst_n low during CAPT of an ADD -> no resp_valid, acc=0, all ALU outputs 0; next LOAD 9'h1FF completes normally.
- Requester 0 drops req_valid while requester 1 is being served -> requester 0 is never granted; only resp_valid=10 is observed.
